// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Shared reservation-station sizing, tag type and scheduler states.
//  Revision : 1.0
// ============================================================================
package core_pkg;

    localparam int RS_ENTRIES = 8;

    typedef logic [$clog2(RS_ENTRIES)-1:0] rs_tag_t;

    typedef enum logic [0:0] {
        SCHED_RUN   = 1'b0,
        SCHED_FLUSH = 1'b1
    } sched_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/age_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : age_matrix
//  Purpose  : Pairwise age relation between rows; picks the oldest requester.
//  Revision : 1.0
// ============================================================================
module age_matrix
    import core_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_ENTRIES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic                           i_alloc_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_alloc_idx,
    input  logic [NUM_ENTRIES-1:0]         i_req,
    output logic [NUM_ENTRIES-1:0]         o_sel,
    output logic                           o_found
);

    // r_age_q[i][j] = 1 : row i was allocated before row j
    logic [NUM_ENTRIES-1:0] r_age_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_age_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_is_oldest;

    always_comb begin
        w_age_d = r_age_q;
        if (i_clear) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_age_d[i] = '0;
            end
        end else if (i_alloc_en) begin
            // Column first, then row, so the diagonal ends up cleared.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_age_d[i][i_alloc_idx] = 1'b1;
            end
            w_age_d[i_alloc_idx] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age_q[i] <= '0;
            end
        end else begin
            r_age_q <= w_age_d;
        end
    end

    always_comb begin
        w_is_oldest = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_is_oldest[i] = i_req[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if ((j != i) && i_req[j] && !r_age_q[i][j]) begin
                    w_is_oldest[i] = 1'b0;
                end
            end
        end
    end

    assign o_sel   = w_is_oldest;
    assign o_found = |w_is_oldest;

endmodule : age_matrix
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scheduler
//  Purpose  : Allocates RS rows on dispatch, issues the oldest ready row and
//             drives the control inputs of the unit's dependency matrix.
//  Revision : 1.0
// ============================================================================
module issue_scheduler
    import core_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_ENTRIES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [NUM_ENTRIES-1:0]         disp_deps,
    output logic [$clog2(NUM_ENTRIES)-1:0] disp_tag,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [$clog2(NUM_ENTRIES)-1:0] iss_tag,
    output logic                           dm_w_en,
    output logic [$clog2(NUM_ENTRIES)-1:0] dm_w_row_index,
    output logic [NUM_ENTRIES-1:0]         dm_set_lines,
    output logic                           dm_clear_en,
    output logic [NUM_ENTRIES-1:0]         dm_clear_lines,
    output logic                           dm_free_en,
    output logic [$clog2(NUM_ENTRIES)-1:0] dm_free_row_index,
    input  logic [NUM_ENTRIES-1:0]         dm_ready_vector
);

    localparam int                   C_IDX_W    = $clog2(NUM_ENTRIES);
    localparam logic [C_IDX_W-1:0]   C_LAST_ROW = C_IDX_W'(NUM_ENTRIES - 1);

    sched_state_t             r_state_q, w_state_d;
    logic [C_IDX_W-1:0]       r_flush_cnt_q, w_flush_cnt_d;
    logic [NUM_ENTRIES-1:0]   r_alloc_q, w_alloc_d;
    logic                     r_iss_valid_q, w_iss_valid_d;
    logic [C_IDX_W-1:0]       r_iss_tag_q, w_iss_tag_d;

    logic                     w_in_run;
    logic [C_IDX_W-1:0]       w_disp_tag;
    logic                     w_disp_fire;
    logic                     w_iss_fire;
    logic [NUM_ENTRIES-1:0]   w_tag_onehot;
    logic [NUM_ENTRIES-1:0]   w_iss_onehot;
    logic [NUM_ENTRIES-1:0]   w_held;
    logic [NUM_ENTRIES-1:0]   w_cand;
    logic [NUM_ENTRIES-1:0]   w_sel;
    logic                     w_found;
    logic [C_IDX_W-1:0]       w_sel_tag;

    assign w_in_run     = (r_state_q == SCHED_RUN);
    assign disp_ready   = w_in_run && (|(~r_alloc_q));
    assign disp_tag     = w_disp_tag;
    assign iss_valid    = r_iss_valid_q;
    assign iss_tag      = r_iss_tag_q;

    // flush outranks both handshakes in its own cycle
    assign w_disp_fire  = disp_valid && disp_ready && !flush;
    assign w_iss_fire   = r_iss_valid_q && iss_ready && !flush;

    assign w_tag_onehot = NUM_ENTRIES'(1) << r_iss_tag_q;
    assign w_iss_onehot = w_iss_fire    ? w_tag_onehot : '0;
    assign w_held       = r_iss_valid_q ? w_tag_onehot : '0;
    assign w_cand       = dm_ready_vector & r_alloc_q & ~w_held;

    always_comb begin
        w_disp_tag = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_alloc_q[i]) begin
                w_disp_tag = C_IDX_W'(i);
            end
        end
    end

    age_matrix #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_age_matrix (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (flush),
        .i_alloc_en  (w_disp_fire),
        .i_alloc_idx (w_disp_tag),
        .i_req       (w_cand),
        .o_sel       (w_sel),
        .o_found     (w_found)
    );

    always_comb begin
        w_sel_tag = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel[i]) begin
                w_sel_tag = w_sel_tag | C_IDX_W'(i);
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= SCHED_RUN;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d     = r_state_q;
        w_flush_cnt_d = r_flush_cnt_q;
        case (r_state_q)
            SCHED_RUN: begin
                if (flush) begin
                    w_state_d     = SCHED_FLUSH;
                    w_flush_cnt_d = '0;
                end
            end
            SCHED_FLUSH: begin
                if (flush) begin
                    w_flush_cnt_d = '0;
                end else if (r_flush_cnt_q == C_LAST_ROW) begin
                    w_state_d     = SCHED_RUN;
                    w_flush_cnt_d = '0;
                end else begin
                    w_flush_cnt_d = r_flush_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d     = SCHED_RUN;
                w_flush_cnt_d = '0;
            end
        endcase
    end

    // ---------------- FSM: matrix control outputs ----------------
    always_comb begin
        dm_w_en           = 1'b0;
        dm_w_row_index    = '0;
        dm_set_lines      = '0;
        dm_clear_en       = 1'b0;
        dm_clear_lines    = '0;
        dm_free_en        = 1'b0;
        dm_free_row_index = '0;
        if (r_state_q == SCHED_FLUSH) begin
            dm_free_en        = 1'b1;
            dm_free_row_index = r_flush_cnt_q;
            dm_clear_en       = 1'b1;
            dm_clear_lines    = '1;
        end else begin
            if (w_disp_fire) begin
                dm_w_en        = 1'b1;
                dm_w_row_index = w_disp_tag;
                dm_set_lines   = disp_deps & r_alloc_q & ~w_iss_onehot;
            end
            if (w_iss_fire) begin
                dm_free_en        = 1'b1;
                dm_free_row_index = r_iss_tag_q;
                dm_clear_en       = 1'b1;
                dm_clear_lines    = w_tag_onehot;
            end
        end
    end

    // ---------------- Occupancy and issue register ----------------
    always_comb begin
        w_alloc_d     = r_alloc_q;
        w_iss_valid_d = r_iss_valid_q;
        w_iss_tag_d   = r_iss_tag_q;
        if (flush) begin
            w_alloc_d = '0;
        end else begin
            if (w_iss_fire) begin
                w_alloc_d[r_iss_tag_q] = 1'b0;
            end
            if (w_disp_fire) begin
                w_alloc_d[w_disp_tag] = 1'b1;
            end
        end
        if (flush || !w_in_run) begin
            w_iss_valid_d = 1'b0;
        end else if (!r_iss_valid_q || w_iss_fire) begin
            w_iss_valid_d = w_found;
            if (w_found) begin
                w_iss_tag_d = w_sel_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc_q     <= '0;
            r_iss_valid_q <= 1'b0;
            r_iss_tag_q   <= '0;
        end else begin
            r_alloc_q     <= w_alloc_d;
            r_iss_valid_q <= w_iss_valid_d;
            r_iss_tag_q   <= w_iss_tag_d;
        end
    end

endmodule : issue_scheduler
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scheduler
//  Purpose  : Randomized scoreboard bench with an instruction-level model.
//  Revision : 1.0
// ============================================================================
module tb_issue_scheduler;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int MAXI = 8192;

    logic          clk = 1'b0;
    logic          rst, flush, disp_valid, iss_ready;
    logic [N-1:0]  disp_deps;
    logic          disp_ready, iss_valid;
    logic [IW-1:0] disp_tag, iss_tag;
    logic          dm_w_en, dm_clear_en, dm_free_en;
    logic [IW-1:0] dm_w_row_index, dm_free_row_index;
    logic [N-1:0]  dm_set_lines, dm_clear_lines, dm_ready_vector;

    always #5 clk = ~clk;

    issue_scheduler #(.NUM_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_deps(disp_deps), .disp_tag(disp_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
        .dm_w_en(dm_w_en), .dm_w_row_index(dm_w_row_index), .dm_set_lines(dm_set_lines),
        .dm_clear_en(dm_clear_en), .dm_clear_lines(dm_clear_lines),
        .dm_free_en(dm_free_en), .dm_free_row_index(dm_free_row_index),
        .dm_ready_vector(dm_ready_vector)
    );

    // Dependency matrix the scheduler drives: a row is ready when it has no pending bits.
    logic [N-1:0] dm_rows [N];
    always @(posedge clk) begin
        logic [N-1:0] v;
        for (int r = 0; r < N; r++) begin
            v = dm_rows[r];
            if (dm_w_en && dm_w_row_index == IW'(r)) v = dm_set_lines;
            if (dm_clear_en) v = v & ~dm_clear_lines;
            if (dm_free_en && dm_free_row_index == IW'(r)) v = '0;
            if (rst) v = '0;
            dm_rows[r] <= v;
        end
    end
    always_comb begin
        for (int r = 0; r < N; r++) dm_ready_vector[r] = (dm_rows[r] == '0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { bit disp_ready; bit iss_valid; int iss_tag; bit w_en; bit free_en; } status_t;
    typedef struct { int row; logic [N-1:0] lines; } ev_t;
    status_t st_q[$];
    ev_t     disp_q[$];
    ev_t     free_q[$];

    // Instruction-level reference: each dispatched instruction has a sequence number
    // (its age), the producers it waits on, and the cycle it was dispatched/issued.
    int m_tag[MAXI], m_disp_cyc[MAXI], m_fire_cyc[MAXI];
    int m_dep[MAXI][N];
    int m_occ[N];
    int m_nseq = 0;
    bit m_iv = 0;
    int m_iseq = -1;
    int m_flush_cnt = -1;
    int now = 0;

    function automatic bit is_ready(input int sq);
        if (m_disp_cyc[sq] >= now) return 0;
        for (int k = 0; k < N; k++) begin
            if (m_dep[sq][k] >= 0) begin
                if (m_fire_cyc[m_dep[sq][k]] < 0 || m_fire_cyc[m_dep[sq][k]] >= now) return 0;
            end
        end
        return 1;
    endfunction

    task automatic drive_cycle(input bit dv, input logic [N-1:0] deps, input bit ir, input bit fl);
        status_t s;
        ev_t     e;
        int      lowest, ftag, cand, sq;
        bit      ifire, dfire;
        @(posedge clk);
        #1;
        disp_valid = dv; disp_deps = deps; iss_ready = ir; flush = fl;
        lowest = -1;
        for (int k = N - 1; k >= 0; k--) if (m_occ[k] < 0) lowest = k;
        s.disp_ready = (m_flush_cnt < 0) && (lowest >= 0);
        s.iss_valid  = m_iv;
        s.iss_tag    = m_iv ? m_tag[m_iseq] : 0;
        s.w_en       = 0;
        s.free_en    = 0;
        if (m_flush_cnt >= 0) begin
            s.free_en = 1; e.row = m_flush_cnt; e.lines = '1; free_q.push_back(e);
            if (fl) m_flush_cnt = 0;
            else if (m_flush_cnt == N - 1) m_flush_cnt = -1;
            else m_flush_cnt++;
        end else if (fl) begin
            m_flush_cnt = 0; m_iv = 0;
            for (int k = 0; k < N; k++) m_occ[k] = -1;
        end else begin
            ifire = m_iv && ir;
            ftag  = ifire ? m_tag[m_iseq] : -1;
            if (ifire) begin
                s.free_en = 1; e.row = ftag; e.lines = '0; e.lines[ftag] = 1'b1;
                free_q.push_back(e);
                m_fire_cyc[m_iseq] = now;
            end
            cand = -1;
            for (int k = 0; k < N; k++) begin
                sq = m_occ[k];
                if (sq >= 0 && !(m_iv && sq == m_iseq) && is_ready(sq) && (cand < 0 || sq < cand))
                    cand = sq;
            end
            dfire = dv && s.disp_ready;
            sq = -1;
            if (dfire) begin
                sq = m_nseq++;
                m_tag[sq] = lowest; m_disp_cyc[sq] = now; m_fire_cyc[sq] = -1;
                e.row = lowest; e.lines = '0;
                for (int k = 0; k < N; k++) begin
                    m_dep[sq][k] = -1;
                    if (deps[k] && m_occ[k] >= 0 && k != ftag) begin
                        m_dep[sq][k] = m_occ[k]; e.lines[k] = 1'b1;
                    end
                end
                s.w_en = 1; disp_q.push_back(e);
            end
            if (!m_iv || ifire) begin m_iv = (cand >= 0); m_iseq = cand; end
            if (ifire) m_occ[ftag] = -1;
            if (dfire) m_occ[lowest] = sq;
        end
        st_q.push_back(s);
        now++;
    endtask

    initial begin : monitor
        status_t s;
        ev_t     e;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("disp_ready", 32'(disp_ready), 32'(s.disp_ready));
                check("iss_valid", 32'(iss_valid), 32'(s.iss_valid));
                if (s.iss_valid) check("iss_tag", 32'(iss_tag), 32'(s.iss_tag));
                check("dm_w_en", 32'(dm_w_en), 32'(s.w_en));
                check("dm_free_en", 32'(dm_free_en), 32'(s.free_en));
                check("dm_clear_en", 32'(dm_clear_en), 32'(s.free_en));
                if (dm_w_en) begin
                    if (disp_q.size() == 0) check("disp_q_nonempty", 32'(0), 32'(1));
                    else begin
                        e = disp_q.pop_front();
                        check("dm_w_row_index", 32'(dm_w_row_index), 32'(e.row));
                        check("disp_tag", 32'(disp_tag), 32'(e.row));
                        check("dm_set_lines", 32'(dm_set_lines), 32'(e.lines));
                    end
                end else check("w_data_idle", 32'({dm_w_row_index, dm_set_lines}), 32'(0));
                if (dm_free_en) begin
                    if (free_q.size() == 0) check("free_q_nonempty", 32'(0), 32'(1));
                    else begin
                        e = free_q.pop_front();
                        check("dm_free_row_index", 32'(dm_free_row_index), 32'(e.row));
                        check("dm_clear_lines", 32'(dm_clear_lines), 32'(e.lines));
                    end
                end else check("free_data_idle", 32'({dm_free_row_index, dm_clear_lines}), 32'(0));
            end
        end
    end

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) drive_cycle(0, '0, ir, 0);
    endtask

    initial begin : stim
        for (int k = 0; k < N; k++) m_occ[k] = -1;
        rst = 1; flush = 0; disp_valid = 0; iss_ready = 0; disp_deps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_disp_ready", 32'(disp_ready), 32'(1));
        check("rst_iss_valid", 32'(iss_valid), 32'(0));
        check("rst_iss_tag", 32'(iss_tag), 32'(0));
        check("rst_disp_tag", 32'(disp_tag), 32'(0));
        check("rst_dm_en", 32'({dm_w_en, dm_clear_en, dm_free_en}), 32'(0));
        check("rst_dm_data", 32'({dm_set_lines, dm_clear_lines}), 32'(0));
        @(posedge clk);
        #1 rst = 0;

        // single dispatch, issue two cycles later
        drive_cycle(1, '0, 0, 0);
        drive_cycle(0, '0, 0, 0);
        idle(3, 1);
        // dependency chain A -> B
        drive_cycle(1, '0, 0, 0);
        drive_cycle(1, 8'h01, 0, 0);
        idle(3, 0);
        idle(6, 1);
        // age order with the unit stalled
        for (int i = 0; i < 3; i++) drive_cycle(1, '0, 0, 0);
        idle(4, 0);
        idle(6, 1);
        // fill all rows, try to overfill, then release one
        for (int i = 0; i < N + 2; i++) drive_cycle(1, '0, 0, 0);
        drive_cycle(1, '0, 1, 0);
        drive_cycle(1, '0, 0, 0);
        idle(12, 1);
        // dispatch depending on the row issuing in the same cycle
        for (int i = 0; i < 3; i++) drive_cycle(1, '0, 0, 0);
        drive_cycle(0, '0, 1, 0);
        drive_cycle(0, '0, 1, 0);
        drive_cycle(1, 8'h04, 1, 0);
        idle(6, 1);
        // flush with five rows live, then a flush restarted mid-sweep
        for (int i = 0; i < 5; i++) drive_cycle(1, '0, 0, 0);
        drive_cycle(1, '0, 1, 1);
        idle(10, 1);
        for (int i = 0; i < 3; i++) drive_cycle(1, '0, 0, 0);
        drive_cycle(0, '0, 0, 1);
        idle(3, 0);
        drive_cycle(1, '0, 1, 1);
        idle(10, 1);

        for (int i = 0; i < 2500; i++) begin
            drive_cycle(($urandom % 100) < 60, N'($urandom & $urandom), ($urandom % 100) < 55,
                        ($urandom % 200) == 0);
        end
        idle(30, 1);

        @(negedge clk);
        #1;
        check("disp_q_drained", 32'(disp_q.size()), 32'(0));
        check("free_q_drained", 32'(free_q.size()), 32'(0));
        check("status_q_drained", 32'(st_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_issue_scheduler
`default_nettype wire
